// File: rtl/rp_8bit_io_tmr.sv
// rp_8bit_io_tmr: 8-bit timer/counter on the rp_8bit I/O bus.
// Registers at ADR+0..ADR+4: TCCR, TCNT, OCR, TIMSK, TIFR.
// Overflow (irq_req[0]) and compare-match (irq_req[1]) interrupt requests.
// Optional fast-PWM output enabled by defining RP_8BIT_IO_TMR_PWM_EN;
// otherwise pwm is tied to 0.
module rp_8bit_io_tmr #(
   parameter logic [5:0] ADR = 6'h20,
   parameter int         PSW = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       io_wen,
   input  logic       io_ren,
   input  logic [5:0] io_adr,
   input  logic [7:0] io_wdt,
   input  logic [7:0] io_msk,
   output logic [7:0] io_rdt,
   output logic [1:0] irq_req,
   input  logic [1:0] irq_ack,
   output logic       pwm
);

   // Bit-masked register update: masked bits take write data, others keep.
   function automatic logic [7:0] mask_merge(input logic [7:0] cur,
                                             input logic [7:0] wdt,
                                             input logic [7:0] msk);
      return (wdt & msk) | (cur & ~msk);
   endfunction

   logic [3:0]     tccr;
   logic [7:0]     tcnt;
   logic [7:0]     ocr;
   logic [1:0]     timsk;
   logic [1:0]     tifr;
   logic [PSW-1:0] psc;

   logic [2:0] cs;
   logic       ctc;
   logic [5:0] ofs;
   logic       hit;
   logic       wr_tccr, wr_tcnt, wr_ocr, wr_timsk, wr_tifr;
   logic       running, tick, cnt_tick;
   logic       cmp, ctc_clr, ovf;
   logic [7:0] tcnt_inc;
   logic [7:0] tccr_w, tcnt_w, ocr_w, timsk_w;
   logic [7:0] tcnt_nxt;
   logic [1:0] flag_set, flag_clr, tifr_nxt;
   logic [7:0] rd_val;

   assign cs  = tccr[2:0];
   assign ctc = tccr[3];

   // Address decode: offset from base, no wrap past the top of I/O space.
   assign ofs      = io_adr - ADR;
   assign hit      = (io_adr >= ADR) && (ofs < 6'd5);
   assign wr_tccr  = io_wen && hit && (ofs == 6'd0);
   assign wr_tcnt  = io_wen && hit && (ofs == 6'd1);
   assign wr_ocr   = io_wen && hit && (ofs == 6'd2);
   assign wr_timsk = io_wen && hit && (ofs == 6'd3);
   assign wr_tifr  = io_wen && hit && (ofs == 6'd4);

   // Prescaler tick selection; CS 0/6/7 stop the timer.
   always_comb begin
      running = 1'b0;
      tick    = 1'b0;
      case (cs)
         3'd1: begin running = 1'b1; tick = 1'b1;        end
         3'd2: begin running = 1'b1; tick = &psc[2:0];   end
         3'd3: begin running = 1'b1; tick = &psc[5:0];   end
         3'd4: begin running = 1'b1; tick = &psc[7:0];   end
         3'd5: begin running = 1'b1; tick = &psc[9:0];   end
         default: begin running = 1'b0; tick = 1'b0;     end
      endcase
   end

   // Counter next-state, flag set/clear and masked register write values.
   always_comb begin
      tccr_w   = mask_merge({4'b0, tccr}, io_wdt, io_msk);
      tcnt_w   = mask_merge(tcnt, io_wdt, io_msk);
      ocr_w    = mask_merge(ocr, io_wdt, io_msk);
      timsk_w  = mask_merge({6'b0, timsk}, io_wdt, io_msk);
      // A CPU write to TCNT swallows the tick and its events.
      cnt_tick = tick && !wr_tcnt;
      cmp      = (tcnt == ocr);
      ctc_clr  = ctc && cmp;
      tcnt_inc = ctc_clr ? 8'h00 : tcnt + 8'd1;
      ovf      = (tcnt == 8'hff) && !ctc_clr;
      tcnt_nxt = tcnt;
      if (wr_tcnt)
         tcnt_nxt = tcnt_w;
      else if (cnt_tick)
         tcnt_nxt = tcnt_inc;
      flag_set = {cnt_tick && cmp, cnt_tick && ovf};
      flag_clr = irq_ack;
      if (wr_tifr)
         flag_clr = flag_clr | (io_wdt[1:0] & io_msk[1:0]);
      // Hardware set wins over a same-cycle clear.
      tifr_nxt = (tifr & ~flag_clr) | flag_set;
   end

   // Read mux on current (pre-write) register values.
   always_comb begin
      rd_val = 8'h00;
      if (hit) begin
         case (ofs)
            6'd0:    rd_val = {4'b0, tccr};
            6'd1:    rd_val = tcnt;
            6'd2:    rd_val = ocr;
            6'd3:    rd_val = {6'b0, timsk};
            6'd4:    rd_val = {6'b0, tifr};
            default: rd_val = 8'h00;
         endcase
      end
   end

   // Prescaler: free-running while enabled, cleared on any TCCR write.
   always_ff @(posedge clk) begin
      if (rst || wr_tccr || !running)
         psc <= '0;
      else
         psc <= psc + 1'b1;
   end

   // Register file and counter state.
   always_ff @(posedge clk) begin
      if (rst) begin
         tccr  <= 4'h0;
         tcnt  <= 8'h00;
         ocr   <= 8'h00;
         timsk <= 2'b00;
         tifr  <= 2'b00;
      end else begin
         if (wr_tccr)  tccr  <= tccr_w[3:0];
         if (wr_ocr)   ocr   <= ocr_w;
         if (wr_timsk) timsk <= timsk_w[1:0];
         tcnt <= tcnt_nxt;
         tifr <= tifr_nxt;
      end
   end

   // Registered read data, held while io_ren is low.
   always_ff @(posedge clk) begin
      if (rst)
         io_rdt <= 8'h00;
      else if (io_ren)
         io_rdt <= rd_val;
   end

   assign irq_req = tifr & timsk;

`ifdef RP_8BIT_IO_TMR_PWM_EN
   logic pwm_r;
   // Fast PWM: set when the counter returns to 0, cleared when it reaches OCR.
   always_ff @(posedge clk) begin
      if (rst || !running)
         pwm_r <= 1'b0;
      else if (cnt_tick && (tcnt_inc == ocr))
         pwm_r <= 1'b0;
      else if (cnt_tick && (tcnt_inc == 8'h00))
         pwm_r <= 1'b1;
   end
   assign pwm = pwm_r;
`else
   assign pwm = 1'b0;
`endif

endmodule

// File: tb/tb_rp_8bit_io_tmr.sv
// Directed self-checking bench for rp_8bit_io_tmr.
module tb_rp_8bit_io_tmr;

   logic       clk = 1'b0;
   logic       rst;
   logic       io_wen;
   logic       io_ren;
   logic [5:0] io_adr;
   logic [7:0] io_wdt;
   logic [7:0] io_msk;
   logic [7:0] io_rdt;
   logic [1:0] irq_req;
   logic [1:0] irq_ack;
   logic       pwm;

   int n_asrt = 0;
   int n_fail = 0;
   int hi_cnt;

   rp_8bit_io_tmr #(.ADR(6'h20), .PSW(10)) dut (
      .clk(clk), .rst(rst), .io_wen(io_wen), .io_ren(io_ren),
      .io_adr(io_adr), .io_wdt(io_wdt), .io_msk(io_msk), .io_rdt(io_rdt),
      .irq_req(irq_req), .irq_ack(irq_ack), .pwm(pwm)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [5:0] a, input logic [7:0] d, input logic [7:0] m);
      io_wen = 1'b1; io_adr = a; io_wdt = d; io_msk = m;
      @(posedge clk); #1;
      io_wen = 1'b0; io_wdt = 8'h00; io_msk = 8'h00;
   endtask

   task automatic rd(input string tag, input logic [5:0] a, input logic [7:0] exp);
      io_ren = 1'b1; io_adr = a;
      @(posedge clk); #1;
      io_ren = 1'b0;
      chk(tag, {8'h00, io_rdt}, {8'h00, exp});
   endtask

   initial begin
      rst = 1'b1; io_wen = 1'b0; io_ren = 1'b0; io_adr = 6'h00;
      io_wdt = 8'h00; io_msk = 8'h00; irq_ack = 2'b00;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rdt", {8'h00, io_rdt}, 16'h0000);
      chk("rst_irq", {14'h0, irq_req}, 16'h0000);
      chk("rst_pwm", {15'h0, pwm}, 16'h0000);
      rst = 1'b0;

      // Reset values of all registers and address misses.
      rd("rst_tccr", 6'h20, 8'h00);
      rd("rst_tcnt", 6'h21, 8'h00);
      rd("rst_ocr", 6'h22, 8'h00);
      rd("rst_timsk", 6'h23, 8'h00);
      rd("rst_tifr", 6'h24, 8'h00);
      wr(6'h22, 8'h5a, 8'hff);
      rd("ocr_rb", 6'h22, 8'h5a);
      rd("miss_hi", 6'h25, 8'h00);
      rd("miss_lo", 6'h1f, 8'h00);
      wr(6'h22, 8'h00, 8'hff);

      // Overflow with CS=1, then acknowledge.
      wr(6'h21, 8'hfe, 8'hff);
      wr(6'h23, 8'h01, 8'hff);
      wr(6'h20, 8'h01, 8'hff);
      @(posedge clk); #1;
      chk("ovf_pre_irq", {14'h0, irq_req}, 16'h0000);
      wr(6'h20, 8'h00, 8'hff);
      chk("ovf_irq", {14'h0, irq_req}, 16'h0001);
      rd("ovf_tcnt", 6'h21, 8'h00);
      rd("ovf_tifr", 6'h24, 8'h01);
      irq_ack = 2'b01;
      @(posedge clk); #1;
      irq_ack = 2'b00;
      chk("ack_irq", {14'h0, irq_req}, 16'h0000);
      rd("ack_tifr", 6'h24, 8'h00);

      // CTC mode, CS=2 (/8), OCR=4, streaming reads of TCNT.
      wr(6'h22, 8'h04, 8'hff);
      wr(6'h23, 8'h03, 8'hff);
      wr(6'h20, 8'h0a, 8'hff);
      io_ren = 1'b1; io_adr = 6'h21;
      for (int k = 1; k <= 44; k++) begin
         @(posedge clk); #1;
         chk($sformatf("ctc_tcnt_%0d", k), {8'h00, io_rdt},
             {8'h00, (k - 1 < 40) ? 8'((k - 1) / 8) : 8'h00});
         chk($sformatf("ctc_irq_%0d", k), {14'h0, irq_req},
             (k >= 40) ? 16'h0002 : 16'h0000);
      end
      io_ren = 1'b0;
      wr(6'h20, 8'h00, 8'hff);

      // Overflow tick coinciding with irq_ack[0]: TOV must stay set.
      wr(6'h21, 8'hff, 8'hff);
      wr(6'h20, 8'h01, 8'hff);
      irq_ack = 2'b01;
      io_wen = 1'b1; io_adr = 6'h20; io_wdt = 8'h00; io_msk = 8'hff;
      @(posedge clk); #1;
      irq_ack = 2'b00; io_wen = 1'b0;
      chk("ovf_ack_irq", {14'h0, irq_req}, 16'h0003);
      rd("ovf_ack_tifr", 6'h24, 8'h03);
      rd("ovf_ack_tcnt", 6'h21, 8'h00);

      // Masked writes and masked W1C.
      wr(6'h20, 8'h05, 8'hff);
      wr(6'h20, 8'hff, 8'h08);
      rd("msk_tccr", 6'h20, 8'h0d);
      @(posedge clk); #1;
      chk("rdt_hold", {8'h00, io_rdt}, 16'h000d);
      wr(6'h20, 8'h00, 8'hff);
      wr(6'h24, 8'hff, 8'h01);
      rd("w1c_tov", 6'h24, 8'h02);
      wr(6'h24, 8'hff, 8'hff);
      rd("w1c_all", 6'h24, 8'h00);

      // CPU write to TCNT on a compare tick.
      wr(6'h22, 8'h05, 8'hff);
      wr(6'h21, 8'h05, 8'hff);
      wr(6'h20, 8'h01, 8'hff);
      io_wen = 1'b1; io_adr = 6'h21; io_wdt = 8'h10; io_msk = 8'hff;
      @(posedge clk); #1;
      io_wen = 1'b0;
      rd("cpu_tcnt", 6'h21, 8'h10);
      wr(6'h20, 8'h00, 8'hff);
      rd("cpu_tifr", 6'h24, 8'h00);
      chk("cpu_irq", {14'h0, irq_req}, 16'h0000);

      // Read and write of the same register in one cycle.
      io_ren = 1'b1; io_wen = 1'b1; io_adr = 6'h21; io_wdt = 8'h33; io_msk = 8'hff;
      @(posedge clk); #1;
      io_ren = 1'b0; io_wen = 1'b0;
      chk("rw_pre", {8'h00, io_rdt}, 16'h0012);
      rd("rw_post", 6'h21, 8'h33);

      // Reset while counting.
      wr(6'h20, 8'h01, 8'hff);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("mid_rst_irq", {14'h0, irq_req}, 16'h0000);
      chk("mid_rst_rdt", {8'h00, io_rdt}, 16'h0000);
      rd("mid_rst_tcnt", 6'h21, 8'h00);
      rd("mid_rst_tccr", 6'h20, 8'h00);

      // Waveform output.
      wr(6'h22, 8'h40, 8'hff);
      wr(6'h20, 8'h01, 8'hff);
      repeat (300) @(posedge clk);
      #1;
      hi_cnt = 0;
      for (int k = 0; k < 256; k++) begin
         @(posedge clk); #1;
         if (pwm) hi_cnt++;
      end
`ifdef RP_8BIT_IO_TMR_PWM_EN
      chk("pwm_duty", 16'(hi_cnt), 16'd64);
`else
      chk("pwm_off", 16'(hi_cnt), 16'd0);
`endif
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("pwm_rst", {15'h0, pwm}, 16'h0000);
      rd("pwm_rst_tcnt", 6'h21, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
